input_port_unit: RTL and testbench
==================================

INPUT_PORT_UNIT -- requirements
Module: input_port_unit

Interface
REQ-001 Parameter FIFO_DEPTH, 4, flit slots per input buffer; power of two, at least 2.
REQ-002 Parameter FLIT_WIDTH, 16, flit width in bits.
REQ-003 Parameter ROUTER_X, 0, this router's X coordinate (2 bits).
REQ-004 Parameter ROUTER_Y, 0, this router's Y coordinate (2 bits).
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_flit  in  FLIT_WIDTH  flit from the upstream link.
REQ-008 in_valid  in  1  in_flit is valid this cycle.
REQ-009 in_ready  out  1  buffer can accept a flit; equals not-full.
REQ-010 sa_req  out  1  switch-allocator request; held for the whole packet.
REQ-011 sa_dport  out  3  requested output port: LOCAL=0, WEST=1, NORTH=2, EAST=3, SOUTH=4; 3'b111 means none.
REQ-012 sa_grant  in  1  registered grant from the switch allocator for this input.
REQ-013 out_flit  out  FLIT_WIDTH  flit toward the crossbar, registered.
REQ-014 out_valid  out  1  out_flit is valid this cycle.
REQ-015 err_drop  out  1  one-cycle pulse when a stray non-head flit is discarded.

Function
REQ-016 Flit format: [15:14] type (HEAD=00, BODY=01, TAIL=10, SINGLE=11); head/single flits carry dest_x in [7:6] and dest_y in [5:4].
REQ-017 Push occurs when in_valid and in_ready; the pushed flit is visible at the FIFO head no earlier than the next cycle.
REQ-018 Push and pop in the same cycle are allowed; occupancy is unchanged by that combination.
REQ-019 The occupancy counter is log2(FIFO_DEPTH)+1 bits wide; read and write pointers wrap modulo FIFO_DEPTH.
REQ-020 When full, in_valid is ignored and no flit is overwritten.
REQ-021 XY routing order: dest_x>ROUTER_X gives EAST; dest_x<ROUTER_X gives WEST; otherwise dest_y>ROUTER_Y gives NORTH; dest_y<ROUTER_Y gives SOUTH; otherwise LOCAL.
REQ-022 The FSM has two states, IDLE and ACTIVE.
REQ-023 In IDLE: sa_req=0 and sa_dport=3'b111.
REQ-024 In IDLE with a HEAD or SINGLE flit at the FIFO head: the routed port is latched into dport_q and the FSM moves to ACTIVE; no pop occurs.
REQ-025 In IDLE with a BODY or TAIL flit at the FIFO head: that flit is popped and discarded, err_drop pulses, and the FSM stays in IDLE.
REQ-026 In ACTIVE: sa_req=1 and sa_dport=dport_q, both registered, first asserted the cycle after the head flit is seen.
REQ-027 In ACTIVE with sa_grant=1 and the FIFO non-empty: one flit is popped; out_flit and out_valid register it the next cycle.
REQ-028 In ACTIVE with sa_grant=1 and the FIFO empty: no pop, out_valid=0 (bubble), and sa_req stays high.
REQ-029 Popping a TAIL or SINGLE flit returns the FSM to IDLE; sa_req drops the following cycle.
REQ-030 sa_grant is ignored in IDLE; the allocator's one-cycle lingering grant after sa_req falls causes no pop.
REQ-031 Minimum latency from head-flit push to out_valid is 4 cycles, assuming a one-cycle allocator grant.

Reset
REQ-032 Assertion of rst: FIFO empty, pointers 0, state IDLE, sa_req=0, sa_dport=3'b111, out_valid=0, out_flit=0, err_drop=0, in_ready=1 after the occupancy clears.
REQ-033 Reset mid-packet discards all buffered flits; no partial packet resumes after reset.

Structure
REQ-034 The shared package holds the port enum, flit-type enum, FLIT_WIDTH, the dest field positions, and the XY route function; the switch allocator also uses this package.
REQ-035 The FIFO is one sub-module, Flit_FIFO, with push/pop/full/empty/head ports; the FSM, routing and output register live in input_port_unit.

Verification
REQ-036 At ROUTER (1,1), push SINGLE with dest (2,1), grant 1 cycle after req -> sa_dport=3 (EAST), one out_valid, sa_req drops after the pop.
REQ-037 Push HEAD(dest 1,0), BODY, BODY, TAIL back-to-back with grant held -> sa_dport=4 (SOUTH); four consecutive out_valid cycles in order; sa_req high for exactly that packet.
REQ-038 Push 5 flits with FIFO_DEPTH=4 and no grant -> in_ready=0 after 4 pushes; 5th flit not stored; after the grant, flits 1-4 come out intact.
REQ-039 BODY flit arrives while IDLE -> err_drop pulses once, no sa_req, FIFO empty afterwards.
REQ-040 Grant held while the FIFO is starved mid-packet -> out_valid=0 bubbles, sa_req stays 1, flits resume on refill.
REQ-041 rst asserted mid-packet -> outputs reach reset values immediately; a subsequent new packet routes correctly.

Source files
------------

// File: rtl/input_port_unit_pkg.sv
// Shared router definitions: port and flit-type encodings, flit field positions
// and the dimension-ordered (X first, then Y) route computation.
package input_port_unit_pkg;

    localparam int FLIT_WIDTH = 16;

    localparam int TYPE_MSB   = 15;
    localparam int TYPE_LSB   = 14;
    localparam int DEST_X_MSB = 7;
    localparam int DEST_X_LSB = 6;
    localparam int DEST_Y_MSB = 5;
    localparam int DEST_Y_LSB = 4;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_WEST  = 3'd1,
        PORT_NORTH = 3'd2,
        PORT_EAST  = 3'd3,
        PORT_SOUTH = 3'd4,
        PORT_NONE  = 3'd7
    } port_e;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    function automatic port_e xy_route(input logic [1:0] dest_x, input logic [1:0] dest_y,
                                       input logic [1:0] here_x, input logic [1:0] here_y);
        port_e port_v;
        if (dest_x > here_x) begin
            port_v = PORT_EAST;
        end else if (dest_x < here_x) begin
            port_v = PORT_WEST;
        end else if (dest_y > here_y) begin
            port_v = PORT_NORTH;
        end else if (dest_y < here_y) begin
            port_v = PORT_SOUTH;
        end else begin
            port_v = PORT_LOCAL;
        end
        return port_v;
    endfunction

    // A packet opens with HEAD or SINGLE and closes with TAIL or SINGLE.
    function automatic logic is_first_flit(input logic [1:0] flit_type);
        return (flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE);
    endfunction

    function automatic logic is_last_flit(input logic [1:0] flit_type);
        return (flit_type == FLIT_TAIL) || (flit_type == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/input_port_unit_flit_fifo.sv
// Circular flit buffer with an occupancy counter; the head entry is visible
// combinationally, and writes are refused while full.
module Flit_FIFO
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    import input_port_unit_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: buffers incoming flits, routes each packet's head flit
// with XY routing, requests the switch allocator and forwards granted flits.
module input_port_unit
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FLIT_WIDTH = 16,
    parameter int ROUTER_X   = 0,
    parameter int ROUTER_Y   = 0
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  sa_req,
    output logic [2:0]            sa_dport,
    input  logic                  sa_grant,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_valid,
    output logic                  err_drop
);
    import input_port_unit_pkg::*;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;
    localparam logic [1:0] HERE_X    = 2'(ROUTER_X);
    localparam logic [1:0] HERE_Y    = 2'(ROUTER_Y);

    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [FLIT_WIDTH-1:0] head_flit_s;
    logic [1:0]            head_type_s;
    logic [1:0]            dest_x_s;
    logic [1:0]            dest_y_s;
    port_e                 route_s;
    logic                  pop_s;
    logic                  drop_s;
    logic                  fwd_s;

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [2:0]            dport_q;
    logic [2:0]            dport_d;
    logic                  sa_req_q;
    logic [2:0]            sa_dport_q;
    logic                  out_valid_q;
    logic [FLIT_WIDTH-1:0] out_flit_q;
    logic                  err_drop_q;

    Flit_FIFO #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FLIT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .pop_i   (pop_s),
        .data_i  (in_flit),
        .head_o  (head_flit_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign in_ready    = !fifo_full_s;
    assign head_type_s = head_flit_s[TYPE_MSB:TYPE_LSB];
    assign dest_x_s    = head_flit_s[DEST_X_MSB:DEST_X_LSB];
    assign dest_y_s    = head_flit_s[DEST_Y_MSB:DEST_Y_LSB];
    assign route_s     = xy_route(dest_x_s, dest_y_s, HERE_X, HERE_Y);

    // Packet FSM: a head flit is routed without popping; strays are discarded in IDLE.
    always_comb begin
        state_d = state_q;
        dport_d = dport_q;
        pop_s   = 1'b0;
        drop_s  = 1'b0;
        fwd_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_empty_s) begin
                    state_d = ST_IDLE;
                end else if (is_first_flit(head_type_s)) begin
                    dport_d = route_s;
                    state_d = ST_ACTIVE;
                end else begin
                    pop_s  = 1'b1;
                    drop_s = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // An empty buffer under grant simply produces a bubble.
                if (sa_grant && !fifo_empty_s) begin
                    pop_s = 1'b1;
                    fwd_s = 1'b1;
                    if (is_last_flit(head_type_s)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered allocator/crossbar outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dport_q     <= PORT_NONE;
            sa_req_q    <= 1'b0;
            sa_dport_q  <= PORT_NONE;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dport_q     <= dport_d;
            sa_req_q    <= (state_d == ST_ACTIVE);
            sa_dport_q  <= (state_d == ST_ACTIVE) ? dport_d : PORT_NONE;
            out_valid_q <= fwd_s;
            err_drop_q  <= drop_s;
            if (fwd_s) begin
                out_flit_q <= head_flit_s;
            end
        end
    end

    assign sa_req    = sa_req_q;
    assign sa_dport  = sa_dport_q;
    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_input_port_unit.sv
// Bench for input_port_unit at router (1,1): directed cycle table, a reset
// mid-packet sequence, and a randomized packet stream checked by a scoreboard.
module tb_input_port_unit;

    localparam int DEPTH = 4;
    localparam int FW    = 16;
    localparam int RX    = 1;
    localparam int RY    = 1;
    localparam int LIMIT = 6000;

    localparam logic [1:0] T_HEAD   = 2'b00;
    localparam logic [1:0] T_BODY   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] in_flit = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sa_req;
    logic [2:0]    sa_dport;
    logic          sa_grant = 1'b0;
    logic [FW-1:0] out_flit;
    logic          out_valid;
    logic          err_drop;

    typedef struct {
        logic          v;
        logic [FW-1:0] flit;
        logic          g;
        logic          rdy;
        logic          req;
        logic [2:0]    dport;
        logic          ov;
        logic [FW-1:0] oflit;
        logic          err;
    } vec_t;

    vec_t          tbl[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [FW-1:0] send_q[$];
    logic [FW-1:0] exp_q[$];
    int            route_q[$];
    int            exp_drops, got_drops, idx, cyc, tag, r, dx, dy, nb;
    logic          req_seen;
    logic [FW-1:0] f, fS, fB0, fH, fB1, fB2, fT, gH, gB1, gB2, gB3, gB4, gT, exp_f;

    input_port_unit #(
        .FIFO_DEPTH (DEPTH),
        .FLIT_WIDTH (FW),
        .ROUTER_X   (RX),
        .ROUTER_Y   (RY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sa_req    (sa_req),
        .sa_dport  (sa_dport),
        .sa_grant  (sa_grant),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .err_drop  (err_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y, input int tg_i);
        logic [9:0] tg;
        tg = 10'(tg_i);
        return {t, tg[9:4], 2'(x), 2'(y), tg[3:0]};
    endfunction

    // XY rule written directly from the routing order.
    function automatic int route(input int x, input int y);
        if (x > RX) return 3;
        if (x < RX) return 1;
        if (y > RY) return 2;
        if (y < RY) return 4;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [FW-1:0] fl, input logic g, input logic rdy,
                       input logic req, input logic [2:0] dp, input logic ov,
                       input logic [FW-1:0] ofl, input logic err);
        vec_t e;
        e.v = v; e.flit = fl; e.g = g; e.rdy = rdy; e.req = req;
        e.dport = dp; e.ov = ov; e.oflit = ofl; e.err = err;
        tbl.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fS  = mk(T_SINGLE, 2, 1, 1);
        fB0 = mk(T_BODY,   0, 0, 2);
        fH  = mk(T_HEAD,   1, 0, 3);
        fB1 = mk(T_BODY,   0, 0, 4);
        fB2 = mk(T_BODY,   0, 0, 5);
        fT  = mk(T_TAIL,   0, 0, 6);
        gH  = mk(T_HEAD,   0, 1, 7);
        gB1 = mk(T_BODY,   0, 0, 8);
        gB2 = mk(T_BODY,   0, 0, 9);
        gB3 = mk(T_BODY,   0, 0, 10);
        gB4 = mk(T_BODY,   0, 0, 11);
        gT  = mk(T_TAIL,   0, 0, 12);

        //   v     flit  g     rdy   req   dport  ov    oflit err
        // SINGLE to (2,1): EAST, grant one cycle after request.
        add(1'b1, fS,  1'b0, 1'b1, 1'b0, 3'd7, 1'b0, '0,  1'b0);
        add(1'b0, '0,  1'b0, 1'b1, 1'b1, 3'd3, 1'b0, '0,  1'b0);
        add(1'b0, '0,  1'b0, 1'b1, 1'b1, 3'd3, 1'b0, '0,  1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b0, 3'd7, 1'b1, fS,  1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b0, 3'd7, 1'b0, '0,  1'b0);
        // Stray BODY while idle.
        add(1'b1, fB0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, '0,  1'b0);
        add(1'b0, '0,  1'b0, 1'b1, 1'b0, 3'd7, 1'b0, '0,  1'b1);
        add(1'b0, '0,  1'b0, 1'b1, 1'b0, 3'd7, 1'b0, '0,  1'b0);
        // Four-flit packet to (1,0): SOUTH, grant held throughout.
        add(1'b1, fH,  1'b1, 1'b1, 1'b0, 3'd7, 1'b0, '0,  1'b0);
        add(1'b1, fB1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, '0,  1'b0);
        add(1'b1, fB2, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, fH,  1'b0);
        add(1'b1, fT,  1'b1, 1'b1, 1'b1, 3'd4, 1'b1, fB1, 1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b1, 3'd4, 1'b1, fB2, 1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b0, 3'd7, 1'b1, fT,  1'b0);
        add(1'b0, '0,  1'b0, 1'b1, 1'b0, 3'd7, 1'b0, '0,  1'b0);
        // Fill to full without grant, fifth flit refused, then drain, starve and refill.
        add(1'b1, gH,  1'b0, 1'b1, 1'b0, 3'd7, 1'b0, '0,  1'b0);
        add(1'b1, gB1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, '0,  1'b0);
        add(1'b1, gB2, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, '0,  1'b0);
        add(1'b1, gB3, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, '0,  1'b0);
        add(1'b1, gT,  1'b0, 1'b0, 1'b1, 3'd1, 1'b0, '0,  1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b1, 3'd1, 1'b1, gH,  1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b1, 3'd1, 1'b1, gB1, 1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b1, 3'd1, 1'b1, gB2, 1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b1, 3'd1, 1'b1, gB3, 1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b1, 3'd1, 1'b0, '0,  1'b0);
        add(1'b1, gB4, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, '0,  1'b0);
        add(1'b1, gT,  1'b1, 1'b1, 1'b1, 3'd1, 1'b1, gB4, 1'b0);
        add(1'b0, '0,  1'b1, 1'b1, 1'b0, 3'd7, 1'b1, gT,  1'b0);
        add(1'b0, '0,  1'b0, 1'b1, 1'b0, 3'd7, 1'b0, '0,  1'b0);

        // Reset values while rst is held.
        @(negedge clk);
        chk("reset.sa_req",    sa_req,    0);
        chk("reset.sa_dport",  sa_dport,  7);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.out_flit",  out_flit,  0);
        chk("reset.err_drop",  err_drop,  0);
        chk("reset.in_ready",  in_ready,  1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid = tbl[i].v;
            in_flit  = tbl[i].flit;
            sa_grant = tbl[i].g;
            @(negedge clk);
            chk($sformatf("row%0d.in_ready", i),  in_ready,  tbl[i].rdy);
            chk($sformatf("row%0d.sa_req", i),    sa_req,    tbl[i].req);
            chk($sformatf("row%0d.sa_dport", i),  sa_dport,  tbl[i].dport);
            chk($sformatf("row%0d.out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("row%0d.err_drop", i),  err_drop,  tbl[i].err);
            if (tbl[i].ov) chk($sformatf("row%0d.out_flit", i), out_flit, tbl[i].oflit);
        end

        // Reset in the middle of a packet, then a fresh packet must route cleanly.
        in_valid = 1'b1; in_flit = mk(T_HEAD, 2, 2, 100); sa_grant = 1'b0;
        @(negedge clk);
        in_flit = mk(T_BODY, 0, 0, 101);
        @(negedge clk);
        chk("mid.sa_req",   sa_req,   1);
        chk("mid.sa_dport", sa_dport, 3);
        in_valid = 1'b0; sa_grant = 1'b1;
        @(negedge clk);
        chk("mid.out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.sa_req",    sa_req,    0);
        chk("rstmid.sa_dport",  sa_dport,  7);
        chk("rstmid.out_valid", out_valid, 0);
        chk("rstmid.out_flit",  out_flit,  0);
        chk("rstmid.err_drop",  err_drop,  0);
        chk("rstmid.in_ready",  in_ready,  1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst.out_valid", out_valid, 0);
            chk("post_rst.sa_req",    sa_req,    0);
        end
        f = mk(T_SINGLE, 1, 2, 102);
        sa_grant = 1'b0; in_valid = 1'b1; in_flit = f;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (sa_req) break;
            @(negedge clk);
        end
        chk("new.sa_req",   sa_req,   1);
        chk("new.sa_dport", sa_dport, 2);
        sa_grant = 1'b1;
        @(negedge clk);
        chk("new.out_valid", out_valid, 1);
        chk("new.out_flit",  out_flit,  f);
        sa_grant = 1'b0;
        @(negedge clk);
        chk("new.sa_req_drop", sa_req, 0);

        // Randomized stream: whole packets interleaved with stray flits.
        exp_drops = 0; got_drops = 0; tag = 200;
        for (int k = 0; k < 60; k++) begin
            r  = $urandom_range(0, 9);
            dx = $urandom_range(0, 3);
            dy = $urandom_range(0, 3);
            if (r < 2) begin
                send_q.push_back(mk((r == 0) ? T_BODY : T_TAIL, dx, dy, tag));
                tag++;
                exp_drops++;
            end else if (r < 5) begin
                f = mk(T_SINGLE, dx, dy, tag); tag++;
                send_q.push_back(f); exp_q.push_back(f);
                route_q.push_back(route(dx, dy));
            end else begin
                nb = $urandom_range(0, 3);
                f = mk(T_HEAD, dx, dy, tag); tag++;
                send_q.push_back(f); exp_q.push_back(f);
                for (int b = 0; b < nb; b++) begin
                    f = mk(T_BODY, $urandom_range(0, 3), $urandom_range(0, 3), tag); tag++;
                    send_q.push_back(f); exp_q.push_back(f);
                end
                f = mk(T_TAIL, 0, 0, tag); tag++;
                send_q.push_back(f); exp_q.push_back(f);
                route_q.push_back(route(dx, dy));
            end
        end

        idx = 0; cyc = 0; req_seen = sa_req;
        while ((idx < send_q.size() || exp_q.size() > 0 || got_drops < exp_drops) && cyc < LIMIT) begin
            if (out_valid) begin
                chk("rnd.expected_flit_pending", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_f = exp_q.pop_front();
                    chk("rnd.out_flit", out_flit, exp_f);
                end
            end
            if (err_drop) got_drops++;
            if (sa_req && !req_seen) begin
                chk("rnd.route_pending", (route_q.size() > 0), 1);
                if (route_q.size() > 0) chk("rnd.sa_dport", sa_dport, route_q.pop_front());
            end
            // Allocator: registered grant follows last cycle's request, sometimes withheld.
            sa_grant = req_seen && ($urandom_range(0, 3) != 0);
            req_seen = sa_req;
            if (idx < send_q.size() && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_flit  = send_q[idx];
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; sa_grant = 1'b0;
        chk("rnd.within_budget", (cyc < LIMIT), 1);
        chk("rnd.drop_count", got_drops, exp_drops);
        chk("rnd.flits_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("rnd.final_sa_req",   sa_req,   0);
        chk("rnd.final_in_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
